mem_arbiter: RTL and testbench

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/cpu_arb_pkg.sv | 17 +
 rtl/mem_arb_pick.sv | 29 ++
 rtl/mem_arbiter.sv | 134 +++++++++++++
 tb/tb_mem_arbiter.sv | 251 +++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_arb_pkg.sv
// Shared types and constants for the two-port memory arbiter.
// The arbitration policy itself is selected by MEM_ARB_RR_EN, see mem_arb_pick.
package cpu_arb_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } arb_state_t;

  localparam logic REQ_IF  = 1'b0;
  localparam logic REQ_MEM = 1'b1;

  // Wide enough for LATENCY-1 with LATENCY up to 15.
  localparam int CNT_W = 4;

endpackage

// File: rtl/mem_arb_pick.sv
// Combinational winner select between the fetch and data ports.
// MEM_ARB_RR_EN defined: round-robin against the last grant; undefined: data port has fixed priority.
module mem_arb_pick
  import cpu_arb_pkg::*;
(
  input  logic if_req,
  input  logic mem_req,
`ifdef MEM_ARB_RR_EN
  input  logic last_grant,
`endif
  output logic any,
  output logic winner
);

  always_comb begin
    any    = if_req | mem_req;
    winner = REQ_IF;
    if (if_req && mem_req) begin
`ifdef MEM_ARB_RR_EN
      winner = (last_grant == REQ_MEM) ? REQ_IF : REQ_MEM;
`else
      winner = REQ_MEM;
`endif
    end else if (mem_req) begin
      winner = REQ_MEM;
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Shares one single-port memory between instruction fetch and the data stage, one transaction at a time.
// Arbitration policy follows MEM_ARB_RR_EN (round-robin when defined, data-port priority otherwise).
module mem_arbiter
  import cpu_arb_pkg::*;
#(
  parameter int LATENCY = 2,
  parameter int AW      = 32,
  parameter int DW      = 32
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          if_req_i,
  input  logic [AW-1:0] if_addr_i,
  output logic          if_gnt_o,
  output logic          if_valid_o,
  output logic [DW-1:0] if_rdata_o,
  input  logic          mem_req_i,
  input  logic          mem_we_i,
  input  logic [AW-1:0] mem_addr_i,
  input  logic [DW-1:0] mem_wdata_i,
  output logic          mem_gnt_o,
  output logic          mem_valid_o,
  output logic [DW-1:0] mem_rdata_o,
  output logic          ram_en_o,
  output logic          ram_we_o,
  output logic [AW-1:0] ram_addr_o,
  output logic [DW-1:0] ram_wdata_o,
  input  logic [DW-1:0] ram_rdata_i
);

  arb_state_t       state_reg, state_next;
  logic [CNT_W-1:0] cnt_reg, cnt_next;
  logic             id_reg;
  logic             we_reg;
  logic [AW-1:0]    addr_reg;
  logic [DW-1:0]    wdata_reg;
  logic [DW-1:0]    if_rdata_reg;
  logic [DW-1:0]    mem_rdata_reg;
  logic             grant;
  logic             capture;
  logic             pick_any;
  logic             pick_winner;

`ifdef MEM_ARB_RR_EN
  logic             last_reg;
`endif

  mem_arb_pick u_pick (
    .if_req     (if_req_i),
    .mem_req    (mem_req_i),
`ifdef MEM_ARB_RR_EN
    .last_grant (last_reg),
`endif
    .any        (pick_any),
    .winner     (pick_winner)
  );

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    grant      = 1'b0;
    capture    = 1'b0;
    case (state_reg)
      IDLE: begin
        if (pick_any) begin
          grant      = 1'b1;
          state_next = ACCESS;
          cnt_next   = CNT_W'(LATENCY - 1);
        end
      end
      ACCESS: begin
        if (cnt_reg == '0) begin
          capture    = 1'b1;
          state_next = RESP;
        end else begin
          cnt_next = cnt_reg - CNT_W'(1);
        end
      end
      RESP:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_reg     <= IDLE;
      cnt_reg       <= '0;
      id_reg        <= REQ_IF;
      we_reg        <= 1'b0;
      addr_reg      <= '0;
      wdata_reg     <= '0;
      if_rdata_reg  <= '0;
      mem_rdata_reg <= '0;
`ifdef MEM_ARB_RR_EN
      last_reg      <= REQ_IF;
`endif
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      if (grant) begin
        id_reg    <= pick_winner;
        we_reg    <= (pick_winner == REQ_MEM) ? mem_we_i : 1'b0;
        addr_reg  <= (pick_winner == REQ_MEM) ? mem_addr_i : if_addr_i;
        wdata_reg <= (pick_winner == REQ_MEM) ? mem_wdata_i : '0;
`ifdef MEM_ARB_RR_EN
        last_reg  <= pick_winner;
`endif
      end
      // Stores report zero read data so the data stage never sees stale load data.
      if (capture) begin
        if (id_reg == REQ_IF) begin
          if_rdata_reg <= ram_rdata_i;
        end else begin
          mem_rdata_reg <= we_reg ? '0 : ram_rdata_i;
        end
      end
    end
  end

  // Grant is combinational on the request, so it is masked while reset is held.
  assign if_gnt_o    = rst_i & grant & (pick_winner == REQ_IF);
  assign mem_gnt_o   = rst_i & grant & (pick_winner == REQ_MEM);
  assign if_valid_o  = (state_reg == RESP) && (id_reg == REQ_IF);
  assign mem_valid_o = (state_reg == RESP) && (id_reg == REQ_MEM);
  assign if_rdata_o  = if_rdata_reg;
  assign mem_rdata_o = mem_rdata_reg;

  // Memory strobes decode straight from state, so an asynchronous reset drops them at once.
  assign ram_en_o    = (state_reg == ACCESS);
  assign ram_we_o    = ram_en_o & we_reg;
  assign ram_addr_o  = ram_en_o ? addr_reg : '0;
  assign ram_wdata_o = ram_en_o ? wdata_reg : '0;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: a cycle table at LATENCY=2 plus hand sequences for
// reset abort, arbitration order and back-to-back fetches at LATENCY=1.
module tb_mem_arbiter;

  logic        clk_i = 1'b0;
  logic        rst_i;
  always #5 clk_i = ~clk_i;

  logic        if_req, mem_req, mem_we;
  logic [31:0] if_addr, mem_addr, mem_wdata;
  logic        if_gnt, if_valid, mem_gnt, mem_valid;
  logic [31:0] if_rdata, mem_rdata;
  logic        ram_en, ram_we;
  logic [31:0] ram_addr, ram_wdata, ram_rdata;

  logic        if_req_b, mem_req_b, mem_we_b;
  logic [31:0] if_addr_b, mem_addr_b, mem_wdata_b;
  logic        if_gnt_b, if_valid_b, mem_gnt_b, mem_valid_b;
  logic [31:0] if_rdata_b, mem_rdata_b;
  logic        ram_en_b, ram_we_b;
  logic [31:0] ram_addr_b, ram_wdata_b, ram_rdata_b;

  mem_arbiter #(.LATENCY(2), .AW(32), .DW(32)) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .if_req_i(if_req), .if_addr_i(if_addr), .if_gnt_o(if_gnt),
    .if_valid_o(if_valid), .if_rdata_o(if_rdata),
    .mem_req_i(mem_req), .mem_we_i(mem_we), .mem_addr_i(mem_addr),
    .mem_wdata_i(mem_wdata), .mem_gnt_o(mem_gnt), .mem_valid_o(mem_valid),
    .mem_rdata_o(mem_rdata),
    .ram_en_o(ram_en), .ram_we_o(ram_we), .ram_addr_o(ram_addr),
    .ram_wdata_o(ram_wdata), .ram_rdata_i(ram_rdata)
  );

  mem_arbiter #(.LATENCY(1), .AW(32), .DW(32)) dut_l1 (
    .clk_i(clk_i), .rst_i(rst_i),
    .if_req_i(if_req_b), .if_addr_i(if_addr_b), .if_gnt_o(if_gnt_b),
    .if_valid_o(if_valid_b), .if_rdata_o(if_rdata_b),
    .mem_req_i(mem_req_b), .mem_we_i(mem_we_b), .mem_addr_i(mem_addr_b),
    .mem_wdata_i(mem_wdata_b), .mem_gnt_o(mem_gnt_b), .mem_valid_o(mem_valid_b),
    .mem_rdata_o(mem_rdata_b),
    .ram_en_o(ram_en_b), .ram_we_o(ram_we_b), .ram_addr_o(ram_addr_b),
    .ram_wdata_o(ram_wdata_b), .ram_rdata_i(ram_rdata_b)
  );

  // Word-addressed RAM model; preload runs while reset is held.
  logic [31:0] ram [256];
  logic        preload;
  assign ram_rdata   = ram[ram_addr[9:2]];
  assign ram_rdata_b = ram[ram_addr_b[9:2]];
  always @(posedge clk_i) begin
    if (preload) begin
      for (int i = 0; i < 256; i++) ram[i] <= 32'h0;
      ram[0] <= 32'hCAFEF00D;
      ram[4] <= 32'hDEADBEEF;
      ram[8] <= 32'h0BADF00D;
    end else if (ram_en && ram_we) begin
      ram[ram_addr[9:2]] <= ram_wdata;
    end
  end

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  typedef struct {
    logic        ir;
    logic [31:0] ia;
    logic        mr;
    logic        mw;
    logic [31:0] ma;
    logic [31:0] md;
    logic        ig, mg, iv, mv, re, rw;
    logic [31:0] ra, rd, ird, mrd;
  } vec_t;

  vec_t vecs[$];

  function automatic void add(input logic ir, input logic [31:0] ia, input logic mr,
                              input logic mw, input logic [31:0] ma, input logic [31:0] md,
                              input logic ig, input logic mg, input logic iv, input logic mv,
                              input logic re, input logic rw, input logic [31:0] ra,
                              input logic [31:0] rd, input logic [31:0] ird,
                              input logic [31:0] mrd);
    vec_t v;
    v.ir = ir; v.ia = ia; v.mr = mr; v.mw = mw; v.ma = ma; v.md = md;
    v.ig = ig; v.mg = mg; v.iv = iv; v.mv = mv; v.re = re; v.rw = rw;
    v.ra = ra; v.rd = rd; v.ird = ird; v.mrd = mrd;
    vecs.push_back(v);
  endfunction

  // Waits for the next grant; gap counts cycles from the previous grant cycle.
  task automatic arb_step(input string name, input int exp_who, input int exp_gap,
                          input logic next_if, input logic next_mem);
    int n;
    int who;
    n   = 1;
    who = -1;
    while (who < 0 && n <= 12) begin
      @(negedge clk_i);
      if (if_gnt || mem_gnt) who = (if_gnt && mem_gnt) ? 3 : (mem_gnt ? 1 : 0);
      else begin
        @(posedge clk_i); #1;
        n++;
      end
    end
    check({name, " winner"}, who, exp_who);
    check({name, " gap"}, n, exp_gap);
    $display("arb %s: winner=%0d gap=%0d", name, who, n);
    @(posedge clk_i); #1;
    if_req  = next_if;
    mem_req = next_mem;
  endtask

  localparam logic [31:0] CAFE = 32'hCAFEF00D;
  localparam logic [31:0] BAD  = 32'h0BADF00D;
  localparam logic [31:0] DEAD = 32'hDEADBEEF;

  initial begin
    // cycle table: ir ia mr mw ma md | ig mg iv mv re rw ra rd | ird mrd
    add(1, 0,     1, 0, 'h20, 0,       0, 1, 0, 0,  0, 0, 0,     0,       0,    0);
    add(1, 0,     0, 0, 0,    0,       0, 0, 0, 0,  1, 0, 'h20,  0,       0,    0);
    add(1, 0,     0, 0, 0,    0,       0, 0, 0, 0,  1, 0, 'h20,  0,       0,    0);
    add(1, 0,     0, 0, 0,    0,       0, 0, 0, 1,  0, 0, 0,     0,       0,    BAD);
    add(1, 0,     0, 0, 0,    0,       1, 0, 0, 0,  0, 0, 0,     0,       0,    BAD);
    add(0, 0,     0, 0, 0,    0,       0, 0, 0, 0,  1, 0, 0,     0,       0,    BAD);
    add(0, 0,     0, 0, 0,    0,       0, 0, 0, 0,  1, 0, 0,     0,       0,    BAD);
    add(0, 0,     0, 0, 0,    0,       0, 0, 1, 0,  0, 0, 0,     0,       CAFE, BAD);
    add(0, 0,     1, 0, 'h10, 0,       0, 1, 0, 0,  0, 0, 0,     0,       CAFE, BAD);
    add(1, 'h80,  0, 0, 0,    0,       0, 0, 0, 0,  1, 0, 'h10,  0,       CAFE, BAD);
    add(1, 'h80,  0, 0, 0,    0,       0, 0, 0, 0,  1, 0, 'h10,  0,       CAFE, BAD);
    add(1, 'h80,  0, 0, 0,    0,       0, 0, 0, 1,  0, 0, 0,     0,       CAFE, DEAD);
    add(0, 0,     1, 1, 'h40, 'h1234,  0, 1, 0, 0,  0, 0, 0,     0,       CAFE, DEAD);
    add(0, 0,     0, 0, 0,    0,       0, 0, 0, 0,  1, 1, 'h40,  'h1234,  CAFE, DEAD);
    add(0, 0,     0, 0, 0,    0,       0, 0, 0, 0,  1, 1, 'h40,  'h1234,  CAFE, DEAD);
    add(0, 0,     0, 0, 0,    0,       0, 0, 0, 1,  0, 0, 0,     0,       CAFE, 0);
    add(0, 0,     1, 0, 'h40, 0,       0, 1, 0, 0,  0, 0, 0,     0,       CAFE, 0);
    add(0, 0,     0, 0, 0,    0,       0, 0, 0, 0,  1, 0, 'h40,  0,       CAFE, 0);
    add(0, 0,     0, 0, 0,    0,       0, 0, 0, 0,  1, 0, 'h40,  0,       CAFE, 0);
    add(0, 0,     0, 0, 0,    0,       0, 0, 0, 1,  0, 0, 0,     0,       CAFE, 'h1234);
    add(0, 0,     0, 0, 0,    0,       0, 0, 0, 0,  0, 0, 0,     0,       CAFE, 'h1234);

    // Reset with both requests high: nothing may be granted or driven.
    rst_i = 1'b0; preload = 1'b1;
    if_req = 1; if_addr = 0; mem_req = 1; mem_we = 1; mem_addr = 'h40; mem_wdata = 'h77;
    if_req_b = 0; if_addr_b = 0; mem_req_b = 0; mem_we_b = 0; mem_addr_b = 0; mem_wdata_b = 0;
    repeat (3) @(posedge clk_i);
    @(negedge clk_i);
    check("rst if_gnt", if_gnt, 0);
    check("rst mem_gnt", mem_gnt, 0);
    check("rst valids", {if_valid, mem_valid}, 0);
    check("rst ram_en/we", {ram_en, ram_we}, 0);
    check("rst ram_addr", ram_addr, 0);
    check("rst ram_wdata", ram_wdata, 0);
    check("rst if_rdata", if_rdata, 0);
    check("rst mem_rdata", mem_rdata, 0);
    $display("reset state checked");

    @(posedge clk_i); #1;
    preload = 1'b0;
    rst_i   = 1'b1;
    foreach (vecs[i]) begin
      if_req = vecs[i].ir; if_addr = vecs[i].ia;
      mem_req = vecs[i].mr; mem_we = vecs[i].mw; mem_addr = vecs[i].ma; mem_wdata = vecs[i].md;
      @(negedge clk_i);
      check($sformatf("v%0d if_gnt", i), if_gnt, vecs[i].ig);
      check($sformatf("v%0d mem_gnt", i), mem_gnt, vecs[i].mg);
      check($sformatf("v%0d if_valid", i), if_valid, vecs[i].iv);
      check($sformatf("v%0d mem_valid", i), mem_valid, vecs[i].mv);
      check($sformatf("v%0d ram_en", i), ram_en, vecs[i].re);
      check($sformatf("v%0d ram_we", i), ram_we, vecs[i].rw);
      check($sformatf("v%0d ram_addr", i), ram_addr, vecs[i].ra);
      check($sformatf("v%0d ram_wdata", i), ram_wdata, vecs[i].rd);
      check($sformatf("v%0d if_rdata", i), if_rdata, vecs[i].ird);
      check($sformatf("v%0d mem_rdata", i), mem_rdata, vecs[i].mrd);
      $display("vec %0d: gnt=%b%b valid=%b%b ram_en=%b ram_we=%b addr=%h", i,
               if_gnt, mem_gnt, if_valid, mem_valid, ram_en, ram_we, ram_addr);
      @(posedge clk_i); #1;
    end

    // Store aborted by reset in its second access cycle.
    mem_req = 1; mem_we = 1; mem_addr = 'h44; mem_wdata = 'h5555;
    @(negedge clk_i);
    check("abort store gnt", mem_gnt, 1);
    @(posedge clk_i); #1;
    mem_req = 0; mem_we = 0; mem_wdata = 0;
    @(negedge clk_i);
    check("abort ram_we acc1", ram_we, 1);
    @(posedge clk_i); #2;
    rst_i = 1'b0;
    #1;
    check("abort ram_we async", ram_we, 0);
    check("abort ram_en async", ram_en, 0);
    check("abort mem_rdata clr", mem_rdata, 0);
    check("abort if_rdata clr", if_rdata, 0);
    repeat (2) begin
      @(negedge clk_i);
      check("abort no valid", {if_valid, mem_valid}, 0);
    end
    $display("store aborted by reset");

    // Release, load 0x20, then contend with both ports requesting.
    @(posedge clk_i); #1;
    rst_i = 1'b1;
    mem_req = 1; mem_addr = 'h20;
    @(negedge clk_i);
    check("post-rst mem_gnt", mem_gnt, 1);
    check("post-rst no valid", mem_valid, 0);
    @(posedge clk_i); #1;
    if_req = 1; if_addr = 0;
`ifdef MEM_ARB_RR_EN
    arb_step("arb1", 0, 4, 1, 1);
`else
    arb_step("arb1", 1, 4, 1, 1);
`endif
    arb_step("arb2", 1, 4, 1, 0);
    arb_step("arb3", 0, 4, 0, 0);
    repeat (2) @(posedge clk_i);
    @(negedge clk_i);
    check("arb3 if_valid", if_valid, 1);
    check("arb3 if_rdata", if_rdata, CAFE);

    // Back-to-back fetches on the LATENCY=1 instance.
    @(posedge clk_i); #1;
    if_req_b = 1; if_addr_b = 'h10;
    for (int k = 0; k < 9; k++) begin
      @(negedge clk_i);
      check($sformatf("l1 c%0d if_gnt", k), if_gnt_b, (k % 3) == 0);
      check($sformatf("l1 c%0d if_valid", k), if_valid_b, (k % 3) == 2);
      check($sformatf("l1 c%0d ram_en", k), ram_en_b, (k % 3) == 1);
      check($sformatf("l1 c%0d ram_addr", k), ram_addr_b, ((k % 3) == 1) ? 32'h10 : 32'h0);
      check($sformatf("l1 c%0d idle mem side", k),
            {mem_gnt_b, mem_valid_b, ram_we_b, 1'b0}, 0);
      check($sformatf("l1 c%0d ram_wdata", k), ram_wdata_b | mem_rdata_b, 0);
      if ((k % 3) == 2) check($sformatf("l1 c%0d if_rdata", k), if_rdata_b, DEAD);
      $display("l1 cycle %0d: gnt=%b valid=%b ram_en=%b", k, if_gnt_b, if_valid_b, ram_en_b);
      @(posedge clk_i); #1;
    end
    if_req_b = 0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
